// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer.
package ldm_stm_sequencer_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_WB   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int         WORD_BYTES = 4;
   localparam logic [3:0] PC_IDX     = 4'd15;
   localparam int         REG_COUNT  = 16;

endpackage

// File: rtl/ldm_stm_sequencer_reg_list_encoder.sv
// Lowest-set-bit encoder for a 16-entry register list, with a nonzero flag.
module ldm_stm_sequencer_reg_list_encoder
   import ldm_stm_sequencer_pkg::*;
(
   input  logic [REG_COUNT-1:0] list,
   output logic [3:0]           idx,
   output logic                 nz
);

   // Scan from the top so the lowest set bit is the last assignment to win.
   always_comb begin
      idx = '0;
      for (int i = REG_COUNT - 1; i >= 0; i--) begin
         if (list[i]) idx = 4'(i);
      end
   end

   assign nz = |list;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Sequences LDM/STM block transfers one register per memory access, lowest register first,
// with optional base writeback and R15 loads diverted to a PC-load strobe.
module ldm_stm_sequencer
   import ldm_stm_sequencer_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 Reset,
   input  logic                 start,
   input  logic                 is_load,
   input  logic                 up,
   input  logic                 writeback,
   input  logic [3:0]           base_reg,
   input  logic [DATA_W-1:0]    base_val,
   input  logic [REG_COUNT-1:0] reg_list,
   input  logic [DATA_W-1:0]    rf_rd,
   input  logic                 mem_ready,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic                 busy,
   output logic                 done,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [DATA_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   output logic [3:0]           rf_a1,
   output logic [3:0]           rf_a3,
   output logic                 rf_we,
   output logic [DATA_W-1:0]    rf_wd,
   output logic                 pc_load
);

   function automatic logic [4:0] popcount(input logic [REG_COUNT-1:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < REG_COUNT; i++) c = c + 5'(v[i]);
      return c;
   endfunction

   state_t                state, next_state;
   logic                  load_q;
   logic                  wb_q;
   logic                  wb_write_q;
   logic [3:0]            base_reg_q;
   logic [REG_COUNT-1:0]  list_q;
   logic [DATA_W-1:0]     addr_q;
   logic [DATA_W-1:0]     final_q;

   logic [3:0]            cur;
   logic                  list_nz;
   logic [REG_COUNT-1:0]  remaining;
   logic [4:0]            count;
   logic [DATA_W-1:0]     span;
   logic [DATA_W-1:0]     start_addr;
   logic [DATA_W-1:0]     final_addr;
   logic                  take_start;

   ldm_stm_sequencer_reg_list_encoder u_enc (
      .list (list_q),
      .idx  (cur),
      .nz   (list_nz)
   );

   assign remaining  = list_q & ~({{(REG_COUNT-1){1'b0}}, 1'b1} << cur);
   assign count      = popcount(reg_list);
   assign span       = DATA_W'(int'(count) * WORD_BYTES);
   assign start_addr = up ? base_val : base_val - span;
   assign final_addr = up ? base_val + span : base_val - span;
   assign take_start = (state == S_IDLE) && start;

   always_ff @(posedge clk) begin
      if (!Reset) state <= S_IDLE;
      else        state <= next_state;
   end

   always_ff @(posedge clk) begin
      if (!Reset) begin
         load_q     <= 1'b0;
         wb_q       <= 1'b0;
         wb_write_q <= 1'b0;
         base_reg_q <= '0;
         list_q     <= '0;
         addr_q     <= '0;
         final_q    <= '0;
      end else if (take_start) begin
         load_q     <= is_load;
         wb_q       <= writeback;
         // A loaded base wins over writeback; index 15 is never stored by the register file.
         wb_write_q <= writeback && (base_reg != PC_IDX) && !(is_load && reg_list[base_reg]);
         base_reg_q <= base_reg;
         list_q     <= reg_list;
         addr_q     <= start_addr;
         final_q    <= final_addr;
      end else if (state == S_XFER && mem_ready) begin
         list_q <= remaining;
         addr_q <= addr_q + DATA_W'(WORD_BYTES);
      end
   end

   always_comb begin
      next_state = state;
      busy       = (state != S_IDLE);
      done       = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      rf_a1      = '0;
      rf_a3      = '0;
      rf_we      = 1'b0;
      rf_wd      = '0;
      pc_load    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) next_state = (count == '0) ? S_DONE : S_XFER;
         end
         S_XFER: begin
            mem_req  = list_nz;
            mem_addr = addr_q;
            if (load_q) begin
               rf_a3 = cur;
               if (mem_ready) begin
                  rf_wd = mem_rdata;
                  if (cur == PC_IDX) pc_load = 1'b1;
                  else               rf_we   = 1'b1;
               end
            end else begin
               mem_we    = 1'b1;
               rf_a1     = cur;
               mem_wdata = rf_rd;
            end
            if (!list_nz)
               next_state = S_DONE;
            else if (mem_ready && remaining == '0)
               next_state = wb_q ? S_WB : S_DONE;
         end
         S_WB: begin
            rf_we      = wb_write_q;
            rf_a3      = base_reg_q;
            rf_wd      = final_q;
            next_state = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: a transaction-level model predicts accesses, register writes and done timing.
module tb_ldm_stm_sequencer;

   localparam int          DW     = 32;
   localparam logic [31:0] PC_VAL = 32'h0000_8008;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] data;
   } acc_t;

   typedef struct packed {
      logic [3:0]  idx;
      logic [31:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          Reset;
   logic          start, is_load, up, writeback;
   logic [3:0]    base_reg;
   logic [DW-1:0] base_val;
   logic [15:0]   reg_list;
   logic [DW-1:0] rf_rd;
   logic          mem_ready;
   logic [DW-1:0] mem_rdata;
   logic          busy, done, mem_req, mem_we, rf_we, pc_load;
   logic [DW-1:0] mem_addr, mem_wdata, rf_wd;
   logic [3:0]    rf_a1, rf_a3;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [31:0] env_regs [16];
   logic [31:0] model_regs [16];
   logic        seed_en = 1'b0;
   logic [3:0]  seed_idx = '0;
   logic [31:0] seed_val = '0;

   acc_t        exp_acc [$];
   wr_t         exp_wr [$];
   logic [31:0] exp_pc [$];
   int          exp_done [$];

   ldm_stm_sequencer #(.DATA_W(DW)) dut (
      .clk(clk), .Reset(Reset), .start(start), .is_load(is_load), .up(up),
      .writeback(writeback), .base_reg(base_reg), .base_val(base_val), .reg_list(reg_list),
      .rf_rd(rf_rd), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy), .done(done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .rf_a1(rf_a1), .rf_a3(rf_a3), .rf_we(rf_we), .rf_wd(rf_wd), .pc_load(pc_load)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] memval(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // Register file environment: R15 is never stored, reads of 15 return the PC.
   always @(posedge clk) begin
      if (seed_en) env_regs[seed_idx] <= seed_val;
      else if (rf_we && rf_a3 != 4'd15) env_regs[rf_a3] <= rf_wd;
   end
   assign rf_rd     = (rf_a1 == 4'd15) ? PC_VAL : env_regs[rf_a1];
   assign mem_rdata = mem_ready ? memval(mem_addr) : 32'hDEAD_BEEF;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void unexpected(input string nm, input logic [31:0] act);
      vectors++;
      miscompares++;
      $display("FAIL %s: unexpected event with value %h, expected none (cycle %0d)", nm, act, cyc);
   endfunction

   // Transaction-level prediction of one block transfer.
   function automatic void model_issue(input logic ld, input logic up_i, input logic wb_i,
                                       input logic [3:0] br, input logic [15:0] lst,
                                       input logic [31:0] bv, output int n, output logic wbt);
      logic [31:0] a, fin, d;
      acc_t ac;
      wr_t  w;
      n = 0;
      for (int i = 0; i < 16; i++) if (lst[i]) n++;
      a   = up_i ? bv : bv - 32'(4 * n);
      fin = up_i ? bv + 32'(4 * n) : bv - 32'(4 * n);
      for (int i = 0; i < 16; i++) begin
         if (lst[i]) begin
            if (ld) begin
               ac = '{addr: a, we: 1'b0, data: 32'h0};
               exp_acc.push_back(ac);
               d = memval(a);
               if (i == 15) exp_pc.push_back(d);
               else begin
                  w = '{idx: 4'(i), data: d};
                  exp_wr.push_back(w);
                  model_regs[i] = d;
               end
            end else begin
               ac = '{addr: a, we: 1'b1, data: (i == 15) ? PC_VAL : model_regs[i]};
               exp_acc.push_back(ac);
            end
            a = a + 32'd4;
         end
      end
      wbt = (n > 0) && wb_i;
      if (wbt && br != 4'd15 && !(ld && lst[br])) begin
         w = '{idx: br, data: fin};
         exp_wr.push_back(w);
         model_regs[br] = fin;
      end
   endfunction

   task automatic set_reg(input logic [3:0] i, input logic [31:0] v);
      seed_idx = i; seed_val = v; seed_en = 1'b1;
      model_regs[i] = v;
      @(posedge clk); #1;
      seed_en = 1'b0;
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_ctl"}, {26'b0, busy, done, mem_req, mem_we, rf_we, pc_load}, 32'h0);
      chk({nm, "_addr"}, mem_addr, 32'h0);
      chk({nm, "_data"}, mem_wdata | rf_wd, 32'h0);
      chk({nm, "_idx"}, {24'b0, rf_a1, rf_a3}, 32'h0);
   endtask

   // wmode: 0 = always ready, 1 = random waits plus input noise while busy, 2 = two waits on the 2nd transfer
   task automatic run_xfer(input logic ld, input logic up_i, input logic wb_i, input logic [3:0] br,
                           input logic [15:0] lst, input int wmode);
      int n, waits, got, c0;
      logic wbt, r;
      logic [31:0] bv;
      bv = (br == 4'd15) ? PC_VAL : model_regs[br];
      model_issue(ld, up_i, wb_i, br, lst, bv, n, wbt);
      c0 = cyc;
      start = 1'b1; is_load = ld; up = up_i; writeback = wb_i;
      base_reg = br; base_val = bv; reg_list = lst; mem_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; waits = 0; got = 0;
      while (got < n) begin
         case (wmode)
            1:       r = ($urandom_range(0, 3) != 0);
            2:       r = !(got == 1 && waits < 2);
            default: r = 1'b1;
         endcase
         mem_ready = r;
         if (r) got++; else waits++;
         if (wmode == 1) begin
            start = 1'($urandom_range(0, 1)); is_load = 1'($urandom_range(0, 1));
            up = 1'($urandom_range(0, 1)); writeback = 1'($urandom_range(0, 1));
            base_reg = 4'($urandom_range(0, 15)); base_val = $urandom; reg_list = 16'($urandom);
         end
         @(posedge clk); #1;
      end
      start = 1'b0; mem_ready = 1'b0;
      exp_done.push_back(c0 + n + waits + int'(wbt) + 1);
      repeat (int'(wbt) + 1) @(posedge clk);
      #1;
      chk_idle("idle_after");
   endtask

   // 4-register LDM interrupted by reset in its 2nd XFER cycle; only the first load lands.
   task automatic run_abort();
      logic [31:0] bv, d;
      acc_t ac;
      wr_t  w;
      bv = model_regs[8];
      d  = memval(bv);
      ac = '{addr: bv, we: 1'b0, data: 32'h0};
      w  = '{idx: 4'd4, data: d};
      exp_acc.push_back(ac);
      exp_wr.push_back(w);
      model_regs[4] = d;
      start = 1'b1; is_load = 1'b1; up = 1'b1; writeback = 1'b1;
      base_reg = 4'd8; base_val = bv; reg_list = 16'h00F0; mem_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; mem_ready = 1'b1;
      @(posedge clk); #1;
      Reset = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;
      Reset = 1'b1;
      chk_idle("abort_reset");
      repeat (3) begin
         mem_ready = 1'b1;
         @(posedge clk); #1;
         chk("abort_busy", {31'b0, busy}, 32'h0);
      end
      mem_ready = 1'b0;
   endtask

   // Monitor: pops expectations whenever the DUT presents an access, write, PC load or done.
   initial begin
      acc_t a;
      wr_t  w;
      logic [31:0] p;
      int   dc;
      logic stall_chk = 1'b0;
      logic [31:0] st_addr = '0, st_wdata = '0;
      logic [7:0]  st_ctl = '0;
      forever begin
         @(negedge clk);
         if (!Reset) begin
            stall_chk = 1'b0;
         end else begin
            if (stall_chk && mem_req) begin
               chk("stall_addr", mem_addr, st_addr);
               chk("stall_wdata", mem_wdata, st_wdata);
               chk("stall_ctl", {24'b0, mem_we, rf_a1, 3'b0}, {24'b0, st_ctl});
            end
            stall_chk = mem_req && !mem_ready;
            st_addr   = mem_addr;
            st_wdata  = mem_wdata;
            st_ctl    = {mem_we, rf_a1, 3'b0};
            if (mem_req && mem_ready) begin
               if (exp_acc.size() == 0) unexpected("access", mem_addr);
               else begin
                  a = exp_acc.pop_front();
                  chk("acc_addr", mem_addr, a.addr);
                  chk("acc_we", {31'b0, mem_we}, {31'b0, a.we});
                  if (a.we) chk("acc_wdata", mem_wdata, a.data);
               end
            end
            if (rf_we) begin
               if (exp_wr.size() == 0) unexpected("rf_write", {28'b0, rf_a3});
               else begin
                  w = exp_wr.pop_front();
                  chk("wr_idx", {28'b0, rf_a3}, {28'b0, w.idx});
                  chk("wr_data", rf_wd, w.data);
               end
            end
            if (pc_load) begin
               chk("pc_load_no_we", {31'b0, rf_we}, 32'h0);
               if (exp_pc.size() == 0) unexpected("pc_load", rf_wd);
               else begin
                  p = exp_pc.pop_front();
                  chk("pc_data", rf_wd, p);
               end
            end
            if (done) begin
               chk("busy_at_done", {31'b0, busy}, 32'h1);
               if (exp_done.size() == 0) unexpected("done", cyc);
               else begin
                  dc = exp_done.pop_front();
                  chk("done_cycle", cyc, dc);
               end
            end
         end
      end
   end

   initial begin
      logic [15:0] lst;
      Reset = 1'b0; start = 1'b0; is_load = 1'b0; up = 1'b0; writeback = 1'b0;
      base_reg = '0; base_val = '0; reg_list = '0; mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      Reset = 1'b1;
      chk_idle("reset");
      for (int i = 0; i < 15; i++) set_reg(4'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101);

      set_reg(4'd13, 32'h100);
      run_xfer(1'b0, 1'b1, 1'b1, 4'd13, 16'h0013, 0);
      set_reg(4'd9, 32'h200);
      run_xfer(1'b1, 1'b0, 1'b0, 4'd9, 16'h8006, 0);
      set_reg(4'd5, 32'h40);
      run_xfer(1'b1, 1'b1, 1'b1, 4'd5, 16'h0021, 0);
      @(posedge clk); #1;
      chk("base_in_list_r5", env_regs[5], memval(32'h44));
      run_xfer(1'b0, 1'b1, 1'b1, 4'd2, 16'h0000, 0);
      set_reg(4'd6, 32'h300);
      run_xfer(1'b0, 1'b1, 1'b1, 4'd6, 16'h0F00, 2);
      run_xfer(1'b1, 1'b0, 1'b1, 4'd6, 16'h00E1, 2);
      set_reg(4'd3, 32'h4);
      run_xfer(1'b0, 1'b0, 1'b1, 4'd3, 16'h0007, 0);
      run_xfer(1'b1, 1'b1, 1'b1, 4'd15, 16'h0C00, 0);
      run_xfer(1'b0, 1'b1, 1'b0, 4'd1, 16'h8001, 1);
      set_reg(4'd8, 32'h500);
      run_abort();
      run_xfer(1'b1, 1'b1, 1'b1, 4'd8, 16'h00F0, 0);

      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 7))
            0:       lst = 16'h0000;
            1:       lst = 16'h0001 << $urandom_range(0, 15);
            default: lst = 16'($urandom);
         endcase
         run_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), lst, 1);
      end

      repeat (4) @(posedge clk);
      #1;
      for (int i = 0; i < 15; i++) chk($sformatf("final_r%0d", i), env_regs[i], model_regs[i]);
      vectors++;
      if (exp_acc.size() + exp_wr.size() + exp_pc.size() + exp_done.size() != 0) begin
         miscompares++;
         $display("FAIL leftover: %0d acc %0d wr %0d pc %0d done still expected, required 0",
                  exp_acc.size(), exp_wr.size(), exp_pc.size(), exp_done.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
